ulpb_layer_driver: RTL and testbench

- Synthesizable layer-side agent for one ulpb_node32-class bus node. It turns a single command into a multi-word TX transaction.
- TX side: drives the node's four-phase TX_REQ/TX_ACK handshake and PEND streaming, and acknowledges TX_SUCC/TX_FAIL.
- RX side: auto-acknowledges received words, with a stall control, and keeps a word count and a signature.
- Replaces hand-written per-node stimulus logic. Sits between a node's layer port and either an on-chip controller or a bench.

---
 rtl/ulpb_pkg.sv | 18 +
 rtl/ulpb_rx_sink.sv | 55 +++++
 rtl/ulpb_layer_driver.sv | 189 ++++++++++++++++++
 tb/tb_ulpb_layer_driver.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ulpb_pkg.sv
// Shared definitions for the ulpb layer driver: default widths and the TX FSM state set.
package ulpb_pkg;

    localparam int unsigned ULPB_ADDR_WIDTH = 8;
    localparam int unsigned ULPB_DATA_WIDTH = 32;
    localparam int unsigned ULPB_LEN_WIDTH  = 6;
    localparam int unsigned ULPB_CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_LOW,
        WAIT_RESP,
        RESP
    } ulpb_state_e;

endpackage

// File: rtl/ulpb_rx_sink.sv
// RX side of a layer agent: auto-acks received words (with stall) and keeps
// a saturating word count, a rotate-xor signature and the last address.
module ulpb_rx_sink
    import ulpb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ULPB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = ULPB_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = ULPB_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rx_addr,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_req,
    output logic                  rx_ack,
    input  logic                  rx_stall,
    input  logic                  rx_clr,
    output logic [CNT_WIDTH-1:0]  rx_words,
    output logic [DATA_WIDTH-1:0] rx_sig,
    output logic [ADDR_WIDTH-1:0] rx_last_addr
);

    logic accept;

    // Stall only gates new acks; an ack already high is released by the requester alone.
    assign accept = rx_req & ~rx_ack & ~rx_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ack       <= 1'b0;
            rx_words     <= '0;
            rx_sig       <= '0;
            rx_last_addr <= '0;
        end else begin
            if (accept) begin
                rx_ack <= 1'b1;
            end else if (!rx_req && rx_ack) begin
                rx_ack <= 1'b0;
            end

            if (rx_clr) begin
                rx_words     <= '0;
                rx_sig       <= '0;
                rx_last_addr <= '0;
            end else if (accept) begin
                if (rx_words != '1) begin
                    rx_words <= rx_words + CNT_WIDTH'(1);
                end
                rx_sig       <= {rx_sig[DATA_WIDTH-2:0], rx_sig[DATA_WIDTH-1]} ^ rx_data;
                rx_last_addr <= rx_addr;
            end
        end
    end

endmodule

// File: rtl/ulpb_layer_driver.sv
// Layer-side agent for one ulpb node: expands a command into a multi-word
// four-phase TX transaction and hosts an auto-acking RX sink.
module ulpb_layer_driver
    import ulpb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ULPB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = ULPB_DATA_WIDTH,
    parameter int unsigned LEN_WIDTH  = ULPB_LEN_WIDTH,
    parameter int unsigned CNT_WIDTH  = ULPB_CNT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_UNDERFLOW,
    input  logic [ADDR_WIDTH-1:0] CMD_DEST,
    input  logic [LEN_WIDTH-1:0]  CMD_LEN,
    input  logic [DATA_WIDTH-1:0] CMD_SEED,
    output logic                  DONE,
    output logic                  RESULT,
    output logic [LEN_WIDTH:0]    WORDS_SENT,
    output logic [ADDR_WIDTH-1:0] TX_ADDR,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_REQ,
    input  logic                  TX_ACK,
    output logic                  TX_PEND,
    input  logic                  TX_SUCC,
    input  logic                  TX_FAIL,
    output logic                  TX_RESP_ACK,
    input  logic [ADDR_WIDTH-1:0] RX_ADDR,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_REQ,
    output logic                  RX_ACK,
    input  logic                  RX_PEND,
    input  logic                  RX_STALL,
    input  logic                  RX_CLR,
    output logic [CNT_WIDTH-1:0]  RX_WORDS,
    output logic [DATA_WIDTH-1:0] RX_SIG,
    output logic [ADDR_WIDTH-1:0] RX_LAST_ADDR
);

    ulpb_state_e           state, state_n;
    logic [ADDR_WIDTH-1:0] cmd_dest, cmd_dest_n;
    logic [DATA_WIDTH-1:0] cmd_seed, cmd_seed_n;
    logic [LEN_WIDTH-1:0]  cmd_len, cmd_len_n;
    logic                  cmd_underflow, cmd_underflow_n;
    logic [LEN_WIDTH-1:0]  word_idx, word_idx_n;
    logic [LEN_WIDTH:0]    words_sent_n;
    logic [ADDR_WIDTH-1:0] tx_addr_n;
    logic [DATA_WIDTH-1:0] tx_data_n;
    logic                  tx_req_n, tx_pend_n, tx_resp_ack_n;
    logic                  done_n, result_n;
    logic                  resp_in, in_tx;
    logic                  unused_rx_pend;

    assign unused_rx_pend = RX_PEND;
    assign CMD_READY      = (state == IDLE);
    assign resp_in        = TX_SUCC | TX_FAIL;
    assign in_tx          = state inside {ISSUE, WAIT_ACK, WAIT_LOW, WAIT_RESP};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            cmd_dest      <= '0;
            cmd_seed      <= '0;
            cmd_len       <= '0;
            cmd_underflow <= 1'b0;
            word_idx      <= '0;
            WORDS_SENT    <= '0;
            TX_ADDR       <= '0;
            TX_DATA       <= '0;
            TX_REQ        <= 1'b0;
            TX_PEND       <= 1'b0;
            TX_RESP_ACK   <= 1'b0;
            DONE          <= 1'b0;
            RESULT        <= 1'b0;
        end else begin
            state         <= state_n;
            cmd_dest      <= cmd_dest_n;
            cmd_seed      <= cmd_seed_n;
            cmd_len       <= cmd_len_n;
            cmd_underflow <= cmd_underflow_n;
            word_idx      <= word_idx_n;
            WORDS_SENT    <= words_sent_n;
            TX_ADDR       <= tx_addr_n;
            TX_DATA       <= tx_data_n;
            TX_REQ        <= tx_req_n;
            TX_PEND       <= tx_pend_n;
            TX_RESP_ACK   <= tx_resp_ack_n;
            DONE          <= done_n;
            RESULT        <= result_n;
        end
    end

    always_comb begin
        state_n         = state;
        cmd_dest_n      = cmd_dest;
        cmd_seed_n      = cmd_seed;
        cmd_len_n       = cmd_len;
        cmd_underflow_n = cmd_underflow;
        word_idx_n      = word_idx;
        words_sent_n    = WORDS_SENT;
        tx_addr_n       = TX_ADDR;
        tx_data_n       = TX_DATA;
        tx_req_n        = TX_REQ;
        tx_pend_n       = TX_PEND;
        tx_resp_ack_n   = TX_RESP_ACK;
        done_n          = 1'b0;
        result_n        = RESULT;

        unique case (state)
            IDLE: begin
                if (CMD_VALID) begin
                    cmd_dest_n      = CMD_DEST;
                    cmd_seed_n      = CMD_SEED;
                    cmd_len_n       = CMD_LEN;
                    cmd_underflow_n = CMD_UNDERFLOW;
                    word_idx_n      = '0;
                    words_sent_n    = '0;
                    state_n         = ISSUE;
                end
            end
            ISSUE: begin
                // Holding off while ACK is still high keeps REQ from rising into a stale ack.
                if (!TX_ACK) begin
                    tx_addr_n = cmd_dest;
                    tx_data_n = cmd_seed + DATA_WIDTH'(word_idx);
                    tx_pend_n = cmd_underflow | (word_idx < cmd_len);
                    tx_req_n  = 1'b1;
                    state_n   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (TX_ACK) begin
                    tx_req_n     = 1'b0;
                    words_sent_n = WORDS_SENT + (LEN_WIDTH + 1)'(1);
                    if (word_idx < cmd_len) begin
                        word_idx_n = word_idx + LEN_WIDTH'(1);
                        state_n    = WAIT_LOW;
                    end else begin
                        state_n = WAIT_RESP;
                    end
                end
            end
            WAIT_LOW: begin
                if (!TX_ACK) begin
                    state_n = ISSUE;
                end
            end
            WAIT_RESP: begin
            end
            RESP: begin
                if (!resp_in) begin
                    tx_resp_ack_n = 1'b0;
                    done_n        = 1'b1;
                    state_n       = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A node response overrides any TX state; a word acked in the same cycle stays counted.
        if (in_tx && resp_in) begin
            tx_req_n      = 1'b0;
            result_n      = TX_SUCC;
            tx_resp_ack_n = 1'b1;
            state_n       = RESP;
        end
    end

    ulpb_rx_sink #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_rx_sink (
        .clk          (CLK),
        .rst_n        (RESET),
        .rx_addr      (RX_ADDR),
        .rx_data      (RX_DATA),
        .rx_req       (RX_REQ),
        .rx_ack       (RX_ACK),
        .rx_stall     (RX_STALL),
        .rx_clr       (RX_CLR),
        .rx_words     (RX_WORDS),
        .rx_sig       (RX_SIG),
        .rx_last_addr (RX_LAST_ADDR)
    );

endmodule

// File: tb/tb_ulpb_layer_driver.sv
// Scoreboard bench for ulpb_layer_driver: a behavioural node answers the TX
// handshake, expected words/results/RX statistics are queued and monitored.
module tb_ulpb_layer_driver;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int LW = 6;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          CMD_VALID = 1'b0, CMD_UNDERFLOW = 1'b0;
    logic          CMD_READY;
    logic [AW-1:0] CMD_DEST = '0;
    logic [LW-1:0] CMD_LEN = '0;
    logic [DW-1:0] CMD_SEED = '0;
    logic          DONE, RESULT;
    logic [LW:0]   WORDS_SENT;
    logic [AW-1:0] TX_ADDR;
    logic [DW-1:0] TX_DATA;
    logic          TX_REQ, TX_PEND, TX_RESP_ACK;
    logic          TX_ACK = 1'b0, TX_SUCC = 1'b0, TX_FAIL = 1'b0;
    logic [AW-1:0] RX_ADDR = '0;
    logic [DW-1:0] RX_DATA = '0;
    logic          RX_REQ = 1'b0, RX_PEND = 1'b0, RX_STALL = 1'b0, RX_CLR = 1'b0;
    logic          RX_ACK;
    logic [CW-1:0] RX_WORDS;
    logic [DW-1:0] RX_SIG;
    logic [AW-1:0] RX_LAST_ADDR;

    ulpb_layer_driver #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK (CLK), .RESET (RESET),
        .CMD_VALID (CMD_VALID), .CMD_READY (CMD_READY), .CMD_UNDERFLOW (CMD_UNDERFLOW),
        .CMD_DEST (CMD_DEST), .CMD_LEN (CMD_LEN), .CMD_SEED (CMD_SEED),
        .DONE (DONE), .RESULT (RESULT), .WORDS_SENT (WORDS_SENT),
        .TX_ADDR (TX_ADDR), .TX_DATA (TX_DATA), .TX_REQ (TX_REQ), .TX_ACK (TX_ACK),
        .TX_PEND (TX_PEND), .TX_SUCC (TX_SUCC), .TX_FAIL (TX_FAIL), .TX_RESP_ACK (TX_RESP_ACK),
        .RX_ADDR (RX_ADDR), .RX_DATA (RX_DATA), .RX_REQ (RX_REQ), .RX_ACK (RX_ACK),
        .RX_PEND (RX_PEND), .RX_STALL (RX_STALL), .RX_CLR (RX_CLR),
        .RX_WORDS (RX_WORDS), .RX_SIG (RX_SIG), .RX_LAST_ADDR (RX_LAST_ADDR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          pend;
    } word_t;

    typedef struct packed {
        logic        result;
        logic [LW:0] words;
    } done_t;

    typedef struct packed {
        logic [CW-1:0] words;
        logic [DW-1:0] sig;
        logic [AW-1:0] addr;
    } rx_t;

    word_t exp_words[$];
    done_t exp_done[$];
    rx_t   exp_rx[$];

    int checks = 0;
    int errors = 0;

    // RX reference state
    int unsigned   m_words = 0;
    logic [DW-1:0] m_sig = '0;
    logic [AW-1:0] m_addr = '0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void flag(string name);
        checks++;
        errors++;
        $display("FAIL %s: expected event did not occur (got none, required one)", name);
    endfunction

    task automatic tick();
        @(negedge CLK);
    endtask

    // TX monitor: every REQ rise and every DONE pulse is matched against the scoreboard
    initial begin
        logic  prev_req, prev_done;
        word_t w;
        done_t d;
        prev_req  = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (TX_REQ && !prev_req) begin
                chk("req_rise_ack_low", TX_ACK, 0);
                if (exp_words.size() == 0) begin
                    flag("unexpected_tx_word");
                end else begin
                    w = exp_words.pop_front();
                    chk("tx_addr", TX_ADDR, w.addr);
                    chk("tx_data", TX_DATA, w.data);
                    chk("tx_pend", TX_PEND, w.pend);
                end
            end
            if (DONE) begin
                chk("done_one_cycle", prev_done, 0);
                if (exp_done.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    d = exp_done.pop_front();
                    chk("result", RESULT, d.result);
                    chk("words_sent", WORDS_SENT, d.words);
                end
            end
            prev_req  = TX_REQ;
            prev_done = DONE;
        end
    end

    // RX monitor: statistics are compared on each rising RX_ACK
    initial begin
        logic prev_ack;
        rx_t  r;
        prev_ack = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (RX_ACK && !prev_ack) begin
                if (exp_rx.size() == 0) begin
                    flag("unexpected_rx_ack");
                end else begin
                    r = exp_rx.pop_front();
                    chk("rx_words", RX_WORDS, r.words);
                    chk("rx_sig", RX_SIG, r.sig);
                    chk("rx_last_addr", RX_LAST_ADDR, r.addr);
                end
            end
            prev_ack = RX_ACK;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [AW-1:0] dest, input logic [LW-1:0] len,
                            input logic [DW-1:0] seed, input bit uf);
        int n;
        n = 0;
        while (!CMD_READY && n < 200) begin tick(); n++; end
        if (!CMD_READY) flag("cmd_ready");
        CMD_DEST = dest; CMD_LEN = len; CMD_SEED = seed; CMD_UNDERFLOW = uf;
        CMD_VALID = 1'b1;
        tick();
        // a second command while busy must be ignored
        CMD_DEST = ~dest; CMD_SEED = ~seed; CMD_LEN = ~len; CMD_UNDERFLOW = ~uf;
        tick();
        CMD_VALID = 1'b0;
    endtask

    // Behavioural node: acks words until the plan says fail, succeeds after a PEND=0 word,
    // and fails if the driver stops supplying words.
    task automatic node_serve(input int fail_at, input bit fail_ack);
        int   k, n;
        bit   fin;
        logic pend;
        k = 0;
        fin = 0;
        while (!fin) begin
            n = 0;
            while (!TX_REQ && n < 20) begin tick(); n++; end
            if (!TX_REQ) begin
                TX_FAIL = 1'b1;
                fin = 1;
            end else begin
                repeat ($urandom_range(0, 2)) tick();
                if (k == fail_at) begin
                    TX_ACK  = fail_ack;
                    TX_FAIL = 1'b1;
                    fin = 1;
                end else begin
                    pend   = TX_PEND;
                    TX_ACK = 1'b1;
                    n = 0;
                    while (TX_REQ && n < 20) begin tick(); n++; end
                    if (TX_REQ) flag("req_fall");
                    TX_ACK = 1'b0;
                    if (!pend) begin
                        TX_SUCC = 1'b1;
                        fin = 1;
                    end
                    k++;
                end
            end
        end
        n = 0;
        while (!TX_RESP_ACK && n < 20) begin tick(); n++; end
        if (!TX_RESP_ACK) flag("resp_ack_rise");
        TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        n = 0;
        while (TX_RESP_ACK && n < 20) begin tick(); n++; end
        if (TX_RESP_ACK) flag("resp_ack_fall");
    endtask

    task automatic run_tx(input logic [AW-1:0] dest, input int len, input logic [DW-1:0] seed,
                          input bit uf, input int fail_at, input bit fail_ack);
        int last;
        done_t d;
        last = (fail_at <= len) ? fail_at : len;
        for (int k = 0; k <= last; k++)
            exp_words.push_back('{addr: dest, data: seed + DW'(k), pend: (uf || k < len)});
        if (fail_at <= len) begin
            d.result = 1'b0;
            d.words  = (LW + 1)'(fail_at + int'(fail_ack));
        end else begin
            d.result = !uf;
            d.words  = (LW + 1)'(len + 1);
        end
        exp_done.push_back(d);
        send_cmd(dest, LW'(len), seed, uf);
        node_serve(fail_at, fail_ack);
    endtask

    task automatic rx_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input int stall,
                           input bit clr_same, input bit stall_after);
        int n;
        if (clr_same) begin
            m_words = 0; m_sig = '0; m_addr = '0;
        end else begin
            if (m_words < (1 << CW) - 1) m_words++;
            m_sig  = ((m_sig << 1) | (m_sig >> (DW - 1))) ^ d;
            m_addr = a;
        end
        exp_rx.push_back('{words: CW'(m_words), sig: m_sig, addr: m_addr});
        RX_ADDR = a; RX_DATA = d; RX_REQ = 1'b1; RX_PEND = $urandom_range(0, 1);
        RX_STALL = (stall > 0); RX_CLR = clr_same;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("rx_stall_holds_ack", RX_ACK, 0);
        end
        RX_STALL = 1'b0;
        tick();
        RX_CLR = 1'b0;
        n = 0;
        while (!RX_ACK && n < 10) begin tick(); n++; end
        if (!RX_ACK) flag("rx_ack_rise");
        if (stall_after) begin
            RX_STALL = 1'b1;
            tick();
            chk("rx_ack_kept_under_stall", RX_ACK, 1);
        end
        RX_REQ = 1'b0;
        n = 0;
        while (RX_ACK && n < 10) begin tick(); n++; end
        if (RX_ACK) flag("rx_ack_fall");
        RX_STALL = 1'b0;
        RX_DATA = $urandom;
    endtask

    initial begin
        int len, fail_at, n;
        repeat (3) tick();
        chk("reset_cmd_ready", CMD_READY, 1);
        chk("reset_tx_req", TX_REQ, 0);
        chk("reset_done", DONE, 0);
        chk("reset_words_sent", WORDS_SENT, 0);
        chk("reset_tx_data", TX_DATA, 0);
        chk("reset_rx_ack", RX_ACK, 0);
        chk("reset_rx_words", RX_WORDS, 0);
        RESET = 1'b1;
        tick();

        // directed TX cases
        run_tx(8'hcd, 0, 32'h1234_5678, 0, 99, 0);
        run_tx(8'hcd, 7, 32'h0000_00F0, 0, 99, 0);
        run_tx(8'hff, 0, 32'hdead_beef, 0, 0, 0);
        run_tx(8'h3c, 7, 32'h0000_0100, 1, 99, 0);
        run_tx(8'h21, 7, 32'h5555_0000, 0, 3, 0);
        run_tx(8'h21, 7, 32'h5555_1000, 0, 5, 1);
        run_tx(8'h77, 63, 32'hFFFF_FFF0, 0, 99, 0);
        run_tx(8'h78, 5, 32'h0000_0001, 1, 5, 1);

        for (int t = 0; t < 25; t++) begin
            len     = $urandom_range(0, 15);
            fail_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len)) : 99;
            run_tx(AW'($urandom), len, $urandom, ($urandom_range(0, 4) == 0), fail_at,
                   1'($urandom_range(0, 1)));
        end

        // reset in the middle of a stream: outputs clear, no DONE follows
        run_tx(8'hef, 1, 32'h0000_0010, 0, 99, 0);
        for (int k = 0; k < 4; k++)
            exp_words.push_back('{addr: 8'hef, data: 32'hA000_0000 + DW'(k), pend: 1'b1});
        send_cmd(8'hef, 7, 32'hA000_0000, 0);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!TX_REQ && n < 20) begin tick(); n++; end
            TX_ACK = 1'b1;
            n = 0;
            while (TX_REQ && n < 20) begin tick(); n++; end
            TX_ACK = 1'b0;
        end
        n = 0;
        while (!TX_REQ && n < 20) begin tick(); n++; end
        if (!TX_REQ) flag("word3_req");
        RESET = 1'b0;
        #1;
        chk("midreset_tx_req", TX_REQ, 0);
        chk("midreset_tx_pend", TX_PEND, 0);
        chk("midreset_tx_data", TX_DATA, 0);
        chk("midreset_tx_addr", TX_ADDR, 0);
        chk("midreset_resp_ack", TX_RESP_ACK, 0);
        chk("midreset_result", RESULT, 0);
        chk("midreset_words_sent", WORDS_SENT, 0);
        chk("midreset_cmd_ready", CMD_READY, 1);
        m_words = 0; m_sig = '0; m_addr = '0;
        tick();
        RESET = 1'b1;
        tick();
        run_tx(8'hef, 2, 32'hB000_0000, 0, 99, 0);

        // RX side
        rx_word(8'h11, 32'h8000_0001, 0, 0, 0);
        rx_word(8'h12, 32'h0000_00ff, 2, 0, 1);
        rx_word(8'h13, 32'hcafe_f00d, 0, 1, 0);
        rx_word(8'h14, 32'h1234_5678, 0, 0, 0);
        RX_CLR = 1'b1;
        tick();
        RX_CLR = 1'b0;
        m_words = 0; m_sig = '0; m_addr = '0;
        chk("rx_clr_words", RX_WORDS, 0);
        chk("rx_clr_sig", RX_SIG, 0);
        chk("rx_clr_addr", RX_LAST_ADDR, 0);
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 3);
            rx_word(AW'($urandom), $urandom, n, (n == 0) && ($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 1)));
        end

        repeat (5) tick();
        chk("tx_words_drained", exp_words.size(), 0);
        chk("done_drained", exp_done.size(), 0);
        chk("rx_drained", exp_rx.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
